// File: rtl/operand_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// operand_sweep_sequencer
//
// Exhaustively sweeps operand pairs (A, B) over 0..LIMIT into an external
// 64-bit adder and compares the adder's 65-bit SUM against an internally
// tracked expected value. Sweep order is row-major (A outer, B inner). Each
// pair is held for SETTLE wait cycles before SUM is sampled in a one-cycle
// CHECK. Mismatches set a sticky error flag and bump a saturating counter.
//
// Parameters
//   LIMIT   highest operand value swept on A and B (1..254)
//   SETTLE  wait cycles between an operand update and SUM sampling (0..15)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   start       sweep request, accepted only in IDLE
//   sum         65-bit adder result, combinational from a and b
//   a, b        registered operands driven to the adder
//   busy        high while in SETTLE or CHECK
//   done        one-cycle pulse in FIN when the sweep completes
//   err         sticky mismatch flag
//   err_count   mismatch count, saturates at 16'hFFFF
//   pair_count  operand pairs checked in the current or last sweep
// -----------------------------------------------------------------------------
module operand_sweep_sequencer #(
  parameter int unsigned LIMIT  = 32,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [64:0] sum,
  output logic [63:0] a,
  output logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] err_count,
  output logic [15:0] pair_count
);

  localparam int unsigned OP_W   = 64;
  localparam int unsigned SUM_W  = 65;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  localparam logic [OP_W-1:0]   LIM_V    = OP_W'(LIMIT);
  localparam logic [CNT_W-1:0]  SETTLE_V = CNT_W'(SETTLE);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam bit                NO_WAIT  = (SETTLE == 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t             state;
  logic [SUM_W-1:0]   exp_sum;
  logic [CNT_W-1:0]   wait_cnt;
  logic               armed;
  logic               a_at_lim;
  logic               b_at_lim;
  logic               mismatch;

  assign a_at_lim = (a == LIM_V);
  assign b_at_lim = (b == LIM_V);
  assign mismatch = (sum != exp_sum);

  // Status decoded directly from the state register (flop outputs, no input path).
  assign busy = (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_FIN);

  // Sequencer: state, operands, expected sum, wait counter and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a          <= '0;
      b          <= '0;
      exp_sum    <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
      err_count  <= '0;
      pair_count <= '0;
      armed      <= 1'b1;
    end else begin
      // A start level must drop before another sweep can be accepted, so a
      // request held high across a whole sweep does not retrigger it.
      if (!start) begin
        armed <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start && armed) begin
            armed      <= 1'b0;
            a          <= '0;
            b          <= '0;
            exp_sum    <= '0;
            err        <= 1'b0;
            err_count  <= '0;
            pair_count <= '0;
            wait_cnt   <= SETTLE_V;
            state      <= NO_WAIT ? S_CHECK : S_SETTLE;
          end
        end

        S_SETTLE: begin
          // Leaving on a count of 1 makes SETTLE last exactly SETTLE cycles.
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt <= CNT_W'(1)) begin
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          pair_count <= pair_count + STAT_W'(1);
          if (mismatch) begin
            err <= 1'b1;
            if (err_count != STAT_MAX) begin
              err_count <= err_count + STAT_W'(1);
            end
          end

          if (a_at_lim && b_at_lim) begin
            state <= S_FIN;
          end else begin
            if (!b_at_lim) begin
              b       <= b + OP_W'(1);
              exp_sum <= exp_sum + SUM_W'(1);
            end else begin
              // Row wrap: B returns to 0, so the expected sum is the new A.
              b       <= '0;
              a       <= a + OP_W'(1);
              exp_sum <= SUM_W'(a) + SUM_W'(1);
            end
            wait_cnt <= SETTLE_V;
            state    <= NO_WAIT ? S_CHECK : S_SETTLE;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sweep_sequencer.sv
`timescale 1ns/1ps
module tb_operand_sweep_sequencer;

  localparam int unsigned LIM   = 32;
  localparam int unsigned SET0  = 1;
  localparam int unsigned SET1  = 0;
  localparam int          NPAIR = (LIM + 1) * (LIM + 1);

  typedef struct {
    int          done_edge;
    int          done_n;
    int          order_bad;
    int          pairs;
    logic        err;
    logic [15:0] ec;
    logic [15:0] pc;
    logic [63:0] wa;
    logic [63:0] wb;
    bit          hold_ok;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [64:0] sum0, sum1;
  logic [63:0] a0, b0, a1, b1;
  logic        busy0, done0, err0, busy1, done1, err1;
  logic [15:0] ec0, pc0, ec1, pc1;
  bit          fault [0:LIM][0:LIM];
  bit          fhit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Adder model with optional +1 fault injected on selected operand pairs.
  always_comb begin
    fhit = 1'b0;
    if (a0 <= 64'(LIM) && b0 <= 64'(LIM))
      fhit = fault[a0[5:0]][b0[5:0]];
    sum0 = {1'b0, a0} + {1'b0, b0} + 65'(fhit);
  end

  assign sum1 = {1'b0, a1} + {1'b0, b1};

  operand_sweep_sequencer #(.LIMIT(LIM), .SETTLE(SET0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .sum(sum0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .err(err0),
    .err_count(ec0), .pair_count(pc0)
  );

  operand_sweep_sequencer #(.LIMIT(LIM), .SETTLE(SET1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sum(sum1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .err(err1),
    .err_count(ec1), .pair_count(pc1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults();
    for (int i = 0; i <= int'(LIM); i++)
      for (int j = 0; j <= int'(LIM); j++)
        fault[i][j] = 1'b0;
  endtask

  // Pulses start on u0 and observes the whole sweep plus a few idle cycles.
  task automatic run_sweep0(output res_t r);
    int          edges;
    int          idx;
    logic [63:0] la, lb;
    r.done_edge = -1; r.done_n = 0; r.order_bad = 0; r.pairs = 0;
    r.err = 1'bx; r.ec = 'x; r.pc = 'x; r.wa = '1; r.wb = '1; r.hold_ok = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    edges = 0;
    idx = 0;
    la = a0; lb = b0;
    if (a0 !== 64'd0 || b0 !== 64'd0) r.order_bad++;
    while (edges < NPAIR * int'(SET0 + 1) + 4) begin
      tick();
      edges++;
      if (a0 !== la || b0 !== lb) begin
        idx++;
        if (la == 64'd0 && lb == 64'(LIM)) begin r.wa = a0; r.wb = b0; end
        if (a0 !== 64'(idx / int'(LIM + 1)) || b0 !== 64'(idx % int'(LIM + 1))) r.order_bad++;
        la = a0; lb = b0;
      end
      if (done0 === 1'b1) begin
        r.done_n++;
        if (r.done_edge < 0) begin
          r.done_edge = edges; r.err = err0; r.ec = ec0; r.pc = pc0;
        end
      end
      if (r.done_edge >= 0) begin
        if (a0 !== 64'(LIM) || b0 !== 64'(LIM)) r.hold_ok = 1'b0;
        if (err0 !== r.err || ec0 !== r.ec || pc0 !== r.pc) r.hold_ok = 1'b0;
        if (edges > r.done_edge && busy0 !== 1'b0) r.hold_ok = 1'b0;
      end
    end
    r.pairs = idx + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    clear_faults();
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({a0, b0, busy0, done0, err0, ec0, pc0} !== '0) begin
      n_bad++;
      $display("FAIL reset_u0 got a=%0h b=%0h busy=%b done=%b err=%b ec=%0d pc=%0d want all 0",
               a0, b0, busy0, done0, err0, ec0, pc0);
    end
    n_cmp++;
    if ({a1, b1, busy1, done1, err1, ec1, pc1} !== '0) begin
      n_bad++;
      $display("FAIL reset_u1 got a=%0h b=%0h busy=%b done=%b err=%b ec=%0d pc=%0d want all 0",
               a1, b1, busy1, done1, err1, ec1, pc1);
    end
  endtask

  task automatic test_ideal_sweep();
    res_t r;
    int   lat;
    clear_faults();
    run_sweep0(r);
    lat = NPAIR * int'(SET0 + 1);
    n_cmp++;
    if (r.done_edge !== lat) begin
      n_bad++; $display("FAIL ideal_done_edge got %0d want %0d", r.done_edge, lat);
    end
    n_cmp++;
    if (r.done_n !== 1) begin
      n_bad++; $display("FAIL ideal_done_pulses got %0d want 1", r.done_n);
    end
    n_cmp++;
    if (r.order_bad !== 0 || r.pairs !== NPAIR) begin
      n_bad++; $display("FAIL ideal_order got bad=%0d pairs=%0d want 0/%0d", r.order_bad, r.pairs, NPAIR);
    end
    n_cmp++;
    if (r.err !== 1'b0 || r.ec !== 16'd0 || r.pc !== 16'(NPAIR)) begin
      n_bad++; $display("FAIL ideal_stats got err=%b ec=%0d pc=%0d want 0/0/%0d", r.err, r.ec, r.pc, NPAIR);
    end
    n_cmp++;
    if (r.hold_ok !== 1'b1) begin
      n_bad++; $display("FAIL ideal_hold got %b want 1", r.hold_ok);
    end
  endtask

  task automatic test_single_fault();
    res_t r;
    clear_faults();
    fault[5][7] = 1'b1;
    run_sweep0(r);
    n_cmp++;
    if (r.err !== 1'b1 || r.ec !== 16'd1 || r.pc !== 16'(NPAIR)) begin
      n_bad++; $display("FAIL fault57_stats got err=%b ec=%0d pc=%0d want 1/1/%0d", r.err, r.ec, r.pc, NPAIR);
    end
    n_cmp++;
    if (r.hold_ok !== 1'b1) begin
      n_bad++; $display("FAIL fault57_hold got %b want 1", r.hold_ok);
    end
  endtask

  task automatic test_wrap();
    res_t r;
    clear_faults();
    run_sweep0(r);
    n_cmp++;
    if (r.wa !== 64'd1 || r.wb !== 64'd0) begin
      n_bad++; $display("FAIL wrap_pair got (%0d,%0d) want (1,0)", r.wa, r.wb);
    end
    n_cmp++;
    if (r.err !== 1'b0 || r.ec !== 16'd0) begin
      n_bad++; $display("FAIL wrap_cleared got err=%b ec=%0d want 0/0", r.err, r.ec);
    end
    n_cmp++;
    if (a0 !== 64'(LIM) || b0 !== 64'(LIM)) begin
      n_bad++; $display("FAIL wrap_last got (%0d,%0d) want (%0d,%0d)", a0, b0, LIM, LIM);
    end
  endtask

  task automatic test_random_faults();
    res_t r;
    int   k, nexp;
    for (int it = 0; it < 2; it++) begin
      clear_faults();
      k = int'($urandom_range(1, 6));
      for (int i = 0; i < k; i++)
        fault[$urandom_range(0, LIM)][$urandom_range(0, LIM)] = 1'b1;
      nexp = 0;
      for (int i = 0; i <= int'(LIM); i++)
        for (int j = 0; j <= int'(LIM); j++)
          if (fault[i][j]) nexp++;
      run_sweep0(r);
      n_cmp++;
      if (r.err !== 1'b1 || r.ec !== 16'(nexp) || r.pc !== 16'(NPAIR)) begin
        n_bad++;
        $display("FAIL rand_faults_%0d got err=%b ec=%0d pc=%0d want 1/%0d/%0d", it, r.err, r.ec, r.pc, nexp, NPAIR);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    int   i;
    clear_faults();
    fault[2][3] = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    i = 0;
    while (i < 3000 && a0 !== 64'd10) begin tick(); i++; end
    n_cmp++;
    if (a0 !== 64'd10 || err0 !== 1'b1 || busy0 !== 1'b1) begin
      n_bad++; $display("FAIL midreset_reach got a=%0d err=%b busy=%b want 10/1/1", a0, err0, busy0);
    end
    rst = 1'b1; start0 = 1'b1;
    tick();
    rst = 1'b0; start0 = 1'b0;
    n_cmp++;
    if ({a0, b0, busy0, done0, err0, ec0, pc0} !== '0) begin
      n_bad++;
      $display("FAIL midreset_clear got a=%0d b=%0d busy=%b done=%b err=%b ec=%0d pc=%0d want all 0",
               a0, b0, busy0, done0, err0, ec0, pc0);
    end
    tick();
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_bad++; $display("FAIL midreset_priority got busy=%b want 0", busy0);
    end
    clear_faults();
    run_sweep0(r);
    n_cmp++;
    if (r.err !== 1'b0 || r.ec !== 16'd0 || r.pc !== 16'(NPAIR) || r.done_edge !== NPAIR * int'(SET0 + 1)) begin
      n_bad++;
      $display("FAIL midreset_rerun got err=%b ec=%0d pc=%0d done_edge=%0d want 0/0/%0d/%0d",
               r.err, r.ec, r.pc, r.done_edge, NPAIR, NPAIR * int'(SET0 + 1));
    end
  endtask

  task automatic test_settle0_hold();
    int          edges, done_edge, done_n;
    logic [15:0] pc_d;
    bit          restart;
    done_edge = -1; done_n = 0; restart = 1'b0; pc_d = 'x;
    start1 = 1'b1;
    tick();
    edges = 0;
    while (edges < NPAIR + 60) begin
      tick();
      edges++;
      if (done1 === 1'b1) begin
        done_n++;
        if (done_edge < 0) begin done_edge = edges; pc_d = pc1; end
      end
      if (done_edge >= 0 && busy1 !== 1'b0) restart = 1'b1;
    end
    start1 = 1'b0;
    n_cmp++;
    if (done_edge !== NPAIR) begin
      n_bad++; $display("FAIL s0_done_edge got %0d want %0d", done_edge, NPAIR);
    end
    n_cmp++;
    if (done_n !== 1 || restart !== 1'b0) begin
      n_bad++; $display("FAIL s0_single got pulses=%0d restart=%b want 1/0", done_n, restart);
    end
    n_cmp++;
    if (pc_d !== 16'(NPAIR) || err1 !== 1'b0) begin
      n_bad++; $display("FAIL s0_stats got pc=%0d err=%b want %0d/0", pc_d, err1, NPAIR);
    end
  endtask

  initial begin
    test_reset();
    test_ideal_sweep();
    test_single_fault();
    test_wrap();
    test_random_faults();
    test_reset_mid();
    test_settle0_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
